// File: rtl/rom_scan_display.sv
// rom_scan_display: steps an address into an external synchronous ROM, captures
// the returned word and scans it as hex digits onto a common-anode 7-segment display.
module rom_scan_display #(
    parameter int DIGITS      = 4,
    parameter int ADDR_W      = 3,
    parameter int REFRESH_DIV = 18,
    parameter int STEP_FRAMES = 64,
    parameter int BLANK_LZ    = 0
) (
    input  logic                  mclk,
    input  logic                  clr_n,
    input  logic                  mode,
    input  logic                  pause,
    input  logic                  load,
    input  logic [ADDR_W-1:0]     addr_in,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [4*DIGITS-1:0]   rom_data,
    output logic [6:0]            a_to_g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } fetch_state_t;

    logic                   load_sync1;
    logic                   load_sync2;
    logic                   load_prev;
    logic                   load_p;
    logic [REFRESH_DIV-1:0] prescale;
    logic                   tick;
    logic [IDX_W-1:0]       digit_idx;
    logic                   frame_end;
    logic [FRM_W-1:0]       frame_cnt;
    logic                   auto_step;
    logic                   addr_upd;
    logic [ADDR_W-1:0]      addr_q;
    fetch_state_t           state;
    fetch_state_t           state_next;
    logic [4*DIGITS-1:0]    data_q;
    logic [3:0]             nibble;
    logic                   blank;
    logic                   zero_run;
    logic [6:0]             seg_next;
    logic [DIGITS-1:0]      an_next;
    logic                   dp_next;

    // Active-low segment pattern (a..g) for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Two-flop synchronizer for the button plus a delayed copy for edge detection.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            load_sync1 <= 1'b0;
            load_sync2 <= 1'b0;
            load_prev  <= 1'b0;
        end else begin
            load_sync1 <= load;
            load_sync2 <= load_sync1;
            load_prev  <= load_sync2;
        end
    end

    assign load_p = load_sync2 & ~load_prev;

    // Free-running prescaler; its all-ones state paces the digit scan.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    assign tick = &prescale;

    // Digit index walks 0..DIGITS-1 once per tick.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            digit_idx <= '0;
        end else if (tick) begin
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end
    end

    assign frame_end = tick && (digit_idx == IDX_LAST);
    assign auto_step = mode && !pause && frame_end && (frame_cnt == FRM_LAST);
    assign addr_upd  = load_p || auto_step;

    // Frame counter: cleared by manual mode or a load, frozen by pause, wraps on a step.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            frame_cnt <= '0;
        end else if (!mode || load_p) begin
            frame_cnt <= '0;
        end else if (!pause && frame_end) begin
            frame_cnt <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Address register: a load beats an auto step landing in the same cycle.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            addr_q <= '0;
        end else if (load_p) begin
            addr_q <= addr_in;
        end else if (auto_step) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    assign rom_addr = addr_q;

    // Fetch state register; reset lands in WAIT so address 0 is read after release.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Any address change restarts the fetch; otherwise WAIT -> CAPTURE -> IDLE.
    always_comb begin
        state_next = state;
        if (addr_upd) begin
            state_next = WAIT;
        end else begin
            case (state)
                WAIT:    state_next = CAPTURE;
                CAPTURE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Capture the ROM word once the read latency has elapsed.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            data_q <= '0;
        end else if (state == CAPTURE) begin
            data_q <= rom_data;
        end
    end

    // Pick the scanned nibble and decide leading-zero blanking from the top down.
    always_comb begin
        nibble   = 4'h0;
        blank    = 1'b0;
        zero_run = 1'b1;
        an_next  = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (data_q[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                nibble     = data_q[4*i +: 4];
                blank      = (BLANK_LZ != 0) && (i != 0) && zero_run;
                an_next[i] = 1'b0;
            end
        end
        seg_next = blank ? 7'b1111111 : hex_to_seg(nibble);
        dp_next  = !((digit_idx == '0) && mode && !pause);
    end

    // Registered display pins so segments and anodes switch together.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            an     <= '1;
            a_to_g <= 7'b1111111;
            dp     <= 1'b1;
        end else begin
            an     <= an_next;
            a_to_g <= seg_next;
            dp     <= dp_next;
        end
    end

endmodule

// File: doc/rom_scan_display.md
# rom_scan_display

Parametrised ROM viewer that sequences addresses into an external synchronous block ROM, captures each returned word and time-multiplexes it as hex digits onto a common-anode 7-segment display. It takes over the roles of the clock divider, the hex scanner and the button-to-address path in the board top level. It adds auto-step mode, pause, edge-detected loading and a ROM fetch state machine that tolerates one-cycle read latency.

## Interface
- DIGITS, 4: number of displayed hex digits; ROM word width is 4*DIGITS.
- ADDR_W, 3: ROM address width.
- REFRESH_DIV, 18: prescaler width; one digit tick every 2^REFRESH_DIV cycles.
- STEP_FRAMES, 64: full display frames per auto-step (must be ≥1).
- BLANK_LZ, 0: 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- mclk  in  1  system clock; all state on rising edge.
- clr_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = manual, 1 = auto-step.
- pause  in  1  1 = freeze auto-stepping; display keeps scanning.
- load  in  1  asynchronous button; a rising edge loads addr_in.
- addr_in  in  ADDR_W  address to load.
- rom_addr  out  ADDR_W  ROM address; equals the internal address register.
- rom_data  in  4*DIGITS  ROM output, valid one clock after rom_addr is sampled.
- a_to_g  out  7  segments a..g, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  DIGITS  digit enables, active-low, one-hot-zero, registered.

## Operation
- The load input passes through a 2-flop synchronizer, then a rising-edge detect. This produces a one-cycle load_p.
- Prescaler: free-running REFRESH_DIV-bit counter. tick = 1 for one cycle when the counter is all ones.
- Digit index: advances on tick and wraps from DIGITS-1 to 0. frame_end = tick && index == DIGITS-1.
- Frame counter, 0..STEP_FRAMES-1:
  - Increments on frame_end only when mode=1 and pause=0.
  - Frozen when pause=1.
  - Cleared when mode=0 or on load_p.
- Address update priority:
  1. load_p: addr = addr_in.
  2. Auto step (mode=1, pause=0, frame_end, frame counter == STEP_FRAMES-1): addr = addr+1, wrapping from 2^ADDR_W-1 to 0. The frame counter is cleared.
  3. Otherwise addr holds.
- Fetch FSM:
  - States: IDLE, WAIT, CAPTURE.
  - Any address update moves the FSM to WAIT, from any state, which restarts the fetch.
  - WAIT → CAPTURE unconditionally.
  - CAPTURE: data_q ← rom_data, then → IDLE.
  - The displayed word therefore changes exactly 2 cycles after the addr register changes.
- Display:
  - Digit i shows data_q[4i+3:4i]; an[i] low selects it, and an[0] is the rightmost digit.
  - Hex encoding (a_to_g order a..g, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - BLANK_LZ=1: digit i>0 is blanked (a_to_g=1111111, an still asserted) when it and all higher nibbles are zero.
  - dp = 0 only on digit 0 while mode=1 and pause=0; otherwise 1.

## Timing
- Reset (clr_n low, asynchronous):
  - addr=0; prescaler, index and frame counter = 0; data_q=0.
  - FSM=WAIT, so ROM address 0 is fetched automatically after release.
  - an = all ones, a_to_g = 1111111, dp = 1.
- First cycle after release: outputs show digit 0 of data_q (an = ...1110).
  - Cycle 2: data_q holds ROM[0].
  - Cycle 3: a_to_g reflects ROM[0].
- Output registers add 1 cycle from index/data_q to pins.
- Latencies:
  - load edge to addr change: 3 cycles (2 sync + 1 edge/register).
  - addr change to data_q update: 2 cycles.
- Simultaneous load_p and auto step: the load wins and the frame counter is cleared.
- Mode switch 1→0 mid-frame: no step occurs; the address is retained.
- Pause asserted: address and frame counter hold; scanning continues.
- Reset mid-fetch discards the pending capture and restarts from address 0.

## Test plan
- Reset (DIGITS=4, REFRESH_DIV=2, ROM[0]=16'h1234), release clr_n → within 3 cycles, an=1110 with a_to_g=1001100 ("4"). Every 4 cycles the index steps, giving "3", "2", "1" on an 1101/1011/0111.
- Manual load: mode=0, addr_in=5, load pulse held 4 cycles → rom_addr=5 three cycles after the rising edge. data_q=ROM[5] two cycles later. A held-high load loads only once.
- Auto-step: mode=1, STEP_FRAMES=2, REFRESH_DIV=2 → rom_addr increments every 32 cycles, 7→0 wraps, and dp=0 on digit 0.
- Pause: assert pause mid-count for 100 cycles → rom_addr unchanged and dp=1. After release, the step occurs after the remaining frames.
- Collision: load_p on the same cycle as an auto-step frame_end with addr_in=2 → addr=2, not addr+1, and the next step comes a full STEP_FRAMES later.
- BLANK_LZ=1, ROM word 16'h0040 → digits 3 and 2 show 1111111, digit 1 shows "4", digit 0 shows "0". An async reset mid-WAIT leaves data_q=ROM[0] afterwards.
